// File: rtl/i2so_ser_pkg.sv
// Shared constants, state/debug types and the word-select rule for the I2S
// output serializer.
package i2so_ser_pkg;

  localparam int FRAME_BITS = 32;
  localparam int SLOT_BITS  = 16;
  localparam logic WS_LEFT  = 1'b0;

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] WS_FIRST = 5'(SLOT_BITS - 1);
  localparam logic [4:0] WS_LAST  = 5'(FRAME_BITS - 2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    state_e     state;
    logic [4:0] bit_idx;
    logic       sck_rise;
  } dbg_t;

  // ws leads the data by one bit, so it flips on the bit before each slot's MSB.
  function automatic logic ws_for_bit(input logic [4:0] b);
    return (b >= WS_FIRST && b <= WS_LAST) ? ~WS_LEFT : WS_LEFT;
  endfunction

endpackage

// File: rtl/i2so_ser_sckgen.sv
// Bit-clock generator: divides clk by 2*SCK_DIV and flags the clk cycle on
// which sck is about to rise or fall.
module i2so_sckgen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = $clog2(SCK_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(SCK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = en && (div_cnt == DIV_MAX);
  assign rise_stb = wrap && !sck;
  assign fall_stb = wrap && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2so_ser.sv
// I2S master transmitter: one-word holding buffer, frame loader and MSB-first
// serializer with standard one-bit-delayed word select.
module i2so_ser
  import i2so_ser_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] in_dat,
  input  logic        in_xfc,
  output logic        in_rdy,
  output logic        sck,
  output logic        ws,
  output logic        sdo,
  output logic        und,
  output logic        ovf,
  output dbg_t        dbg
);

  state_e      state, state_nxt;
  logic [31:0] hold, hold_nxt;
  logic        hold_full, hold_full_nxt;
  logic [31:0] shift;
  logic [31:0] load_word;
  logic [4:0]  b, b_nxt;
  logic        load, und_nxt, ovf_nxt;
  logic        gen_en, fall_stb, rise_stb;

  assign gen_en = (state == ST_RUN) && en;
  assign b_nxt  = b + 5'd1;
  assign in_rdy = ~hold_full;
  assign dbg    = '{state: state, bit_idx: b, sck_rise: rise_stb};

  i2so_sckgen #(.SCK_DIV(SCK_DIV)) u_sckgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (gen_en),
    .sck      (sck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // Handshake: in_xfc is a one-cycle strobe sampled on the clk edge; the word
  // is taken when in_rdy=1 or when a frame load frees the holding register in
  // that same cycle, otherwise it is dropped and ovf flags it a cycle later.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    load_word     = '0;
    und_nxt       = 1'b0;
    ovf_nxt       = 1'b0;
    load          = 1'b0;

    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (!en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    load = ((state == ST_IDLE) && en) || (fall_stb && (b == LAST_BIT));

    if (load) begin
      if (hold_full) begin
        load_word     = hold;
        hold_full_nxt = 1'b0;
      end else if (in_xfc) begin
        load_word = in_dat;
      end else begin
        und_nxt = 1'b1;
      end
    end

    // An empty register plus a load means the word bypassed straight to shift.
    if (in_xfc) begin
      if (hold_full && !load) begin
        ovf_nxt = 1'b1;
      end else if (hold_full || !load) begin
        hold_nxt      = in_dat;
        hold_full_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      b         <= '0;
      ws        <= WS_LEFT;
      sdo       <= 1'b0;
      und       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      und       <= und_nxt;
      ovf       <= ovf_nxt;
      if (state_nxt == ST_IDLE) begin
        b   <= '0;
        ws  <= WS_LEFT;
        sdo <= 1'b0;
      end else if (state == ST_IDLE) begin
        shift <= load_word;
        b     <= '0;
        ws    <= WS_LEFT;
        sdo   <= load_word[31];
      end else if (fall_stb) begin
        b  <= b_nxt;
        ws <= ws_for_bit(b_nxt);
        if (b == LAST_BIT) begin
          shift <= load_word;
          sdo   <= load_word[31];
        end else begin
          sdo <= shift[LAST_BIT - b_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2so_ser.sv
// Directed/randomized bench for i2so_ser: captures sdo/ws on every sck rise
// and compares whole frames against words and the I2S slot rule.
module tb_i2so_ser;
  import i2so_ser_pkg::*;

  localparam int SCK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, in_xfc;
  logic [31:0] in_dat;
  logic        in_rdy, sck, ws, sdo, und, ovf;
  dbg_t        dbg;

  i2so_ser #(.SCK_DIV(SCK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_dat(in_dat), .in_xfc(in_xfc),
    .in_rdy(in_rdy), .sck(sck), .ws(ws), .sdo(sdo), .und(und), .ovf(ovf),
    .dbg(dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic bit_q[$];
  logic ws_q[$];
  int rise_n, last_rise, first_rise, bad_period, und_n, ovf_n;
  logic prev_sck;
  logic [31:0] feed_q[$];
  bit auto_feed, pend_valid;
  logic [31:0] pend_dat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bit_q.delete();
    ws_q.delete();
    rise_n = 0; last_rise = -1; first_rise = -1;
    bad_period = 0; und_n = 0; ovf_n = 0;
  endtask

  // One clk: sample at negedge, then drive inputs for the next rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (sck && !prev_sck) begin
      bit_q.push_back(sdo);
      ws_q.push_back(ws);
      rise_n++;
      if (rise_n == 1) first_rise = cyc;
      if (last_rise >= 0 && (cyc - last_rise) != 2 * SCK_DIV) bad_period++;
      last_rise = cyc;
    end
    prev_sck = sck;
    if (und) und_n++;
    if (ovf) ovf_n++;
    if (pend_valid) begin
      in_xfc = 1'b1; in_dat = pend_dat; pend_valid = 1'b0;
    end else if (auto_feed && feed_q.size() > 0 && in_rdy) begin
      in_xfc = 1'b1; in_dat = feed_q.pop_front();
    end else begin
      in_xfc = 1'b0; in_dat = $urandom;
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    pend_valid = 1'b1;
    pend_dat = w;
    cycle();
  endtask

  task automatic run_rises(input int n, input string tag);
    int target, budget, k;
    target = rise_n + n;
    budget = (n + 2) * 2 * SCK_DIV + 8;
    k = 0;
    while (rise_n < target && k < budget) begin
      cycle();
      k++;
    end
    if (rise_n < target) check({tag, " sck timeout"}, rise_n, target);
  endtask

  // Reference: bit b carries word[31-b]; ws already shows the channel of bit b+1.
  task automatic check_frame(input string tag, input logic [31:0] word);
    logic [31:0] got_d, got_w, exp_w;
    if (bit_q.size() < 32) begin
      check({tag, " bit count"}, bit_q.size(), 32);
      return;
    end
    for (int i = 0; i < 32; i++) begin
      got_d[31-i] = bit_q.pop_front();
      got_w[31-i] = ws_q.pop_front();
      exp_w[31-i] = (((i + 1) % 32) >= 16) ? 1'b1 : 1'b0;
    end
    check({tag, " sdo"}, got_d, word);
    check({tag, " ws"}, got_w, exp_w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_xfc = 1'b0; pend_valid = 1'b0;
    auto_feed = 1'b0; feed_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sck = 1'b0;
    cycle();
    clear_mon();
  endtask

  logic [31:0] w0, w1, w2, w3, wa, wb, wc, wd;
  logic [31:0] sw[3];
  int entry_cyc;

  initial begin
    rst_n = 1'b0; en = 1'b0; in_xfc = 1'b0; in_dat = '0;
    pend_valid = 1'b0; auto_feed = 1'b0; prev_sck = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset sck", sck, 0);
    check("reset in_rdy", in_rdy, 1);
    rst_n = 1'b1;
    cycle(); cycle();

    // Reset state and first capture
    check("idle sck", sck, 0);
    check("idle ws", ws, 0);
    check("idle sdo", sdo, 0);
    check("idle und", und, 0);
    check("idle ovf", ovf, 0);
    check("idle in_rdy", in_rdy, 1);
    w0 = 32'hA5A5_3C3C;
    write_word(w0);
    cycle();
    check("capture in_rdy", in_rdy, 0);
    check("capture ovf", ovf_n, 0);

    // First frame: timing and content of the preloaded word
    clear_mon();
    en = 1'b1;
    cycle();
    entry_cyc = cyc;
    check("entry sdo", sdo, w0[31]);
    check("entry sck", sck, 0);
    run_rises(32, "f1");
    check("first rise delay", first_rise - entry_cyc, SCK_DIV);
    en = 1'b0;
    cycle();
    check_frame("f1", w0);
    check("f1 und", und_n, 0);
    check("f1 period", bad_period, 0);
    check("f1 in_rdy", in_rdy, 1);
    check("stop sck", sck, 0);
    check("stop sdo", sdo, 0);

    // Back-to-back stream, each word written as soon as in_rdy rises
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sw[i] = $urandom;
      feed_q.push_back(sw[i]);
    end
    auto_feed = 1'b1;
    repeat (3) cycle();
    clear_mon();
    en = 1'b1;
    cycle();
    run_rises(96, "stream");
    en = 1'b0;
    auto_feed = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) check_frame($sformatf("stream%0d", i), sw[i]);
    check("stream und", und_n, 0);
    check("stream ovf", ovf_n, 0);
    check("stream period", bad_period, 0);
    check("stream fed", feed_q.size(), 0);

    // Underrun: no data at all
    do_reset();
    en = 1'b1;
    cycle();
    run_rises(64, "und");
    en = 1'b0;
    cycle();
    check_frame("und0", 32'h0);
    check_frame("und1", 32'h0);
    check("und pulses", und_n, 2);

    // Overflow then bypass at a frame boundary
    do_reset();
    w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
    write_word(w0);
    cycle();
    clear_mon();
    en = 1'b1;
    cycle();
    run_rises(4, "ov");
    write_word(w1);
    cycle();
    check("ov in_rdy", in_rdy, 0);
    write_word(w2);
    cycle();
    check("ov pulse", ovf_n, 1);
    run_rises(64 - rise_n, "ov");
    repeat (SCK_DIV - 2) cycle();
    write_word(w3);
    run_rises(32, "bp");
    en = 1'b0;
    cycle();
    check_frame("ov f0", w0);
    check_frame("ov f1", w1);
    check_frame("bypass f2", w3);
    check("bypass und", und_n, 0);
    check("ov total", ovf_n, 1);
    check("bypass in_rdy", in_rdy, 1);

    // Asynchronous reset at b=20, then restart with a bypassed word
    do_reset();
    wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
    write_word(wa);
    cycle();
    clear_mon();
    en = 1'b1;
    cycle();
    run_rises(21, "rs");
    rst_n = 1'b0;
    #1;
    check("rst sck", sck, 0);
    check("rst ws", ws, 0);
    check("rst sdo", sdo, 0);
    check("rst in_rdy", in_rdy, 1);
    @(negedge clk);
    @(negedge clk);
    in_xfc = 1'b1;
    in_dat = wb;
    rst_n = 1'b1;
    prev_sck = 1'b0;
    clear_mon();
    cycle();
    check("restart sdo", sdo, wb[31]);
    run_rises(32, "rs2");
    check_frame("restart", wb);
    check("restart und", und_n, 0);

    // en low mid-frame keeps the held word, which restarts from b=0
    en = 1'b0;
    cycle();
    write_word(wc);
    cycle();
    en = 1'b1;
    cycle();
    run_rises(20, "hold");
    write_word(wd);
    cycle();
    en = 1'b0;
    cycle();
    check("en low sck", sck, 0);
    check("en low ws", ws, 0);
    check("en low sdo", sdo, 0);
    check("en low in_rdy", in_rdy, 0);
    clear_mon();
    en = 1'b1;
    cycle();
    check("held sdo", sdo, wd[31]);
    run_rises(32, "held");
    en = 1'b0;
    cycle();
    check_frame("held", wd);
    check("held und", und_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
